// File: rtl/timer_service_master.sv
// timer_service_master
//   Avalon-MM initiator that owns one interval-timer slave (16-bit data, 3-bit word
//   address). It loads the 32-bit period and run mode into the timer, services the timer
//   interrupt by clearing the status register, and counts serviced timeouts in hardware.
//   This gives fabric logic a timebase that does not involve the soft CPU.
//
// Optional feature: define TIMER_SERVICE_SNAPSHOT_EN to add a counter snapshot path
//   (snap_req in, snap_value / snap_valid out). Without the macro those ports and states
//   are absent.
//
// Ports
//   clk, reset_n    single clock, asynchronous active-low reset
//   cfg_period      period loaded into the timer, sampled when start is accepted
//   cfg_cont        1 = continuous, 0 = one-shot, sampled when start is accepted
//   start           1-cycle request, ignored while busy
//   stop            1-cycle request, held pending until the stop sequence runs
//   busy            a sequence is in progress or the timer is running
//   tick            1-cycle pulse for each serviced timeout
//   tick_count      serviced timeouts since reset, wraps modulo 2**TICK_W
//   av_*            Avalon-MM initiator port to the timer's s1 slave
//   timer_irq       level interrupt from the timer
module timer_service_master #(
  parameter int unsigned TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_cont,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
`ifdef TIMER_SERVICE_SNAPSHOT_EN
  input  logic              snap_req,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
`endif
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              timer_irq
);

  // Timer register map (word addresses).
  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrControl = 3'd1;
  localparam logic [2:0] AddrPeriodL = 3'd2;
  localparam logic [2:0] AddrPeriodH = 3'd3;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
  localparam logic [2:0] AddrSnapL   = 3'd4;
  localparam logic [2:0] AddrSnapH   = 3'd5;
`endif

  localparam logic [15:0] StopWord = 16'h0008;

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StRun,
    StClr,
    StStop,
    StStopClr
`ifdef TIMER_SERVICE_SNAPSHOT_EN
    ,
    StSnapW,
    StSnapRl,
    StSnapRh,
    StSnapDn
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       period_q;
  logic              cont_q;
  logic              stop_q, stop_d;
  logic              ignore_irq_q;
  logic [TICK_W-1:0] tick_count_q;

  logic accept_start;
  logic stop_pend;
  logic irq_pend;

  // A stop arriving this cycle counts as pending so that it beats a same-cycle irq.
  assign accept_start = (state_q == StIdle) && start;
  assign stop_pend    = stop_q | stop;
  // The slave takes a cycle to drop its irq after the status clear, so the first RUN
  // cycle after CLR must not see it.
  assign irq_pend     = timer_irq & ~ignore_irq_q;

`ifdef TIMER_SERVICE_SNAPSHOT_EN
  logic        snap_pend_q, snap_pend_d;
  logic [15:0] snap_lo_q;
  logic [31:0] snap_value_q;
  logic        snap_valid_q;
`else
  // Read data is only consumed by the snapshot path.
  logic unused_readdata;
  assign unused_readdata = ^av_readdata;
`endif

  always_comb begin
    state_d       = state_q;
    stop_d        = stop_q;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'h0000;
    tick          = 1'b0;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
    snap_pend_d   = snap_pend_q;
    if (snap_req && (state_q != StIdle)) begin
      snap_pend_d = 1'b1;
    end
`endif

    // Stop requests are dropped while idle unless they arrive with an accepted start.
    if (stop && ((state_q != StIdle) || start)) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrPl;
        end
      end
      StWrPl: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrPeriodL;
        av_writedata  = period_q[15:0];
        state_d       = StWrPh;
      end
      StWrPh: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrPeriodH;
        av_writedata  = period_q[31:16];
        state_d       = StWrCtrl;
      end
      StWrCtrl: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrControl;
        av_writedata  = {12'b0, 1'b0, 1'b1, cont_q, 1'b1};
        state_d       = stop_pend ? StStop : StRun;
      end
      StRun: begin
        if (stop_pend) begin
          state_d = StStop;
        end else if (irq_pend) begin
          state_d = StClr;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
        end else if (snap_pend_q) begin
          state_d     = StSnapW;
          snap_pend_d = 1'b0;
`endif
        end
      end
      StClr: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrStatus;
        tick          = 1'b1;
        state_d       = cont_q ? StRun : StIdle;
      end
      StStop: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrControl;
        av_writedata  = StopWord;
        state_d       = StStopClr;
      end
      StStopClr: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrStatus;
        stop_d        = 1'b0;
        state_d       = StIdle;
      end
`ifdef TIMER_SERVICE_SNAPSHOT_EN
      // Writing the snap register latches the live counter for the two reads that follow.
      StSnapW: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = AddrSnapL;
        state_d       = StSnapRl;
      end
      StSnapRl: begin
        av_chipselect = 1'b1;
        av_address    = AddrSnapL;
        state_d       = StSnapRh;
      end
      StSnapRh: begin
        av_chipselect = 1'b1;
        av_address    = AddrSnapH;
        state_d       = StSnapDn;
      end
      StSnapDn: begin
        state_d = StRun;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    if (state_d == StIdle) begin
      snap_pend_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      period_q     <= 32'h0;
      cont_q       <= 1'b0;
      stop_q       <= 1'b0;
      ignore_irq_q <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      stop_q       <= stop_d;
      ignore_irq_q <= (state_q == StClr);
      if (accept_start) begin
        period_q <= cfg_period;
        cont_q   <= cfg_cont;
      end
      if (state_q == StClr) begin
        tick_count_q <= tick_count_q + TICK_W'(1);
      end
    end
  end

`ifdef TIMER_SERVICE_SNAPSHOT_EN
  // Read data lags its address by one cycle: low half arrives in SNAP_RH, high in SNAP_DN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pend_q  <= 1'b0;
      snap_lo_q    <= 16'h0;
      snap_value_q <= 32'h0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_pend_q  <= snap_pend_d;
      snap_valid_q <= 1'b0;
      if (state_q == StSnapRh) begin
        snap_lo_q <= av_readdata;
      end
      if (state_q == StSnapDn) begin
        snap_value_q <= {av_readdata, snap_lo_q};
        snap_valid_q <= 1'b1;
      end
    end
  end

  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
`endif

  assign busy       = (state_q != StIdle);
  assign tick_count = tick_count_q;

endmodule
